// File: rtl/serial_logic_unit_if.sv
// Handshake and data bundle for serial_logic_unit: operand/op request side and result/flags side.
interface serial_logic_unit_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [2:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] f;
    logic         zero;
    logic         ones;
    logic         parity;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, f, zero, ones, parity
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, f, zero, ones, parity
    );
endinterface

// File: rtl/serial_logic_unit.sv
// N-bit bitwise logic unit that walks the operands in W-bit chunks and accumulates
// zero/all-ones/parity flags; valid/ready handshakes on request and result.
//
// state | meaning
// IDLE  | in_ready high, waiting for operands
// BUSY  | one chunk of f per cycle, flags accumulating
// DONE  | out_valid high, f and flags held until out_ready
module serial_logic_unit #(
    parameter int N = 32,
    parameter int W = 8
) (
    input logic                 clk,
    input logic                 rst,
    serial_logic_unit_if.slave  s_if
);
    localparam int NCH = N / W;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCH - 1);

    if (N % W != 0) begin : g_bad_width
        $error("serial_logic_unit: N must be a multiple of W");
    end
    if ($bits(s_if.f) != N) begin : g_bad_if
        $error("serial_logic_unit: interface width does not match N");
    end

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_a;
    logic [N-1:0]  r_b;
    logic [2:0]    r_op;
    logic [N-1:0]  r_f;
    logic [N-1:0]  w_f_nxt;
    logic          r_zero;
    logic          r_ones;
    logic          r_par;
    logic          r_zacc;
    logic          r_oacc;
    logic          r_pacc;
    logic [W-1:0]  w_ca;
    logic [W-1:0]  w_cb;
    logic [W-1:0]  w_chunk;
    logic          w_zacc_nxt;
    logic          w_oacc_nxt;
    logic          w_pacc_nxt;
    logic          w_last;

    // Operands shift right each BUSY cycle, so the live chunk is always the low W bits.
    assign w_ca = r_a[W-1:0];
    assign w_cb = r_b[W-1:0];

    always_comb begin
        w_chunk = '0;
        unique case (r_op)
            3'b000:  w_chunk = w_ca & w_cb;
            3'b001:  w_chunk = w_ca | w_cb;
            3'b010:  w_chunk = w_ca ^ w_cb;
            3'b011:  w_chunk = ~(w_ca | w_cb);
            3'b100:  w_chunk = ~(w_ca & w_cb);
            3'b101:  w_chunk = ~(w_ca ^ w_cb);
            3'b110:  w_chunk = w_ca & ~w_cb;
            default: w_chunk = ~w_ca;
        endcase
    end

    // Result fills from the top; after N/W shifts chunk k sits at f[k*W +: W].
    if (NCH == 1) begin : g_single
        assign w_f_nxt = w_chunk;
    end else begin : g_multi
        assign w_f_nxt = {w_chunk, r_f[N-1:W]};
    end

    assign w_zacc_nxt = r_zacc & (w_chunk == '0);
    assign w_oacc_nxt = r_oacc & (w_chunk == '1);
    assign w_pacc_nxt = r_pacc ^ (^w_chunk);
    assign w_last     = (r_cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (s_if.in_valid)  w_state_nxt = S_BUSY;
            S_BUSY:  if (w_last)         w_state_nxt = S_DONE;
            S_DONE:  if (s_if.out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_op   <= '0;
            r_f    <= '0;
            r_zero <= 1'b0;
            r_ones <= 1'b0;
            r_par  <= 1'b0;
            r_zacc <= 1'b0;
            r_oacc <= 1'b0;
            r_pacc <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (s_if.in_valid) begin
                        r_a    <= s_if.a;
                        r_b    <= s_if.b;
                        r_op   <= s_if.op;
                        r_cnt  <= '0;
                        r_zacc <= 1'b1;
                        r_oacc <= 1'b1;
                        r_pacc <= 1'b0;
                    end
                end
                S_BUSY: begin
                    r_a    <= r_a >> W;
                    r_b    <= r_b >> W;
                    r_f    <= w_f_nxt;
                    r_zacc <= w_zacc_nxt;
                    r_oacc <= w_oacc_nxt;
                    r_pacc <= w_pacc_nxt;
                    if (w_last) begin
                        r_zero <= w_zacc_nxt;
                        r_ones <= w_oacc_nxt;
                        r_par  <= w_pacc_nxt;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign s_if.in_ready  = (r_state == S_IDLE);
    assign s_if.out_valid = (r_state == S_DONE);
    assign s_if.f         = r_f;
    assign s_if.zero      = r_zero;
    assign s_if.ones      = r_ones;
    assign s_if.parity    = r_par;
endmodule
